// File: rtl/wb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// wb_pkg : shared FSM states, wait-counter type and sizing helper
// Rev 1.0
//------------------------------------------------------------------------------
package wb_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TERM = 2'd2
  } wb_state_e;

  // Index width that stays legal for a single-word memory.
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ram_bytewr.sv
`default_nettype none
//------------------------------------------------------------------------------
// wb_ram_bytewr : single-port DEPTH x DW RAM, per-byte write, combinational read
// Rev 1.0
//------------------------------------------------------------------------------
module wb_ram_bytewr #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic            clk_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [IW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/wb_slave_mem.sv
`default_nettype none
//------------------------------------------------------------------------------
// wb_slave_mem : Wishbone slave memory with wait states, byte enables, error decode
// Rev 1.0
//------------------------------------------------------------------------------
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int          DW          = 32,
  parameter int          AW          = 32,
  parameter int          DEPTH       = 256,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int          WAIT_STATES = 1
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [AW-1:0]   ADR_I,
  input  logic [DW-1:0]   DAT_I,
  input  logic [DW/8-1:0] SEL_I,
  input  logic            LOCK_I,
  input  logic            TGA_I,
  input  logic            TGC_I,
  input  logic            TGD_I,
  output logic [DW-1:0]   DAT_O,
  output logic            ACK_O,
  output logic            ERR_O,
  output logic            RTY_O,
  output logic            TGD_O
);

  localparam int          BPW     = DW / 8;
  localparam int          OB      = $clog2(BPW);
  localparam int          IW      = idx_width(DEPTH);
  localparam logic [AW:0] LO_ADDR = (AW+1)'(BASE_ADDR);
  localparam logic [AW:0] HI_ADDR = LO_ADDR + (AW+1)'(DEPTH * BPW);
  localparam wait_cnt_t   WS_CNT  = wait_cnt_t'(WAIT_STATES);

  wb_state_e       state_q;
  wait_cnt_t       cnt_q;
  logic            ack_q, errt_q;
  logic [DW-1:0]   rdat_q;
  logic [IW-1:0]   idx_q, idx_d;
  logic            we_q, bad_q, bad_d;
  logic [DW-1:0]   wdat_q;
  logic [BPW-1:0]  sel_q;
  logic [AW:0]     adr_ext, offset;
  logic            misalign, out_of_range;
  logic [BPW-1:0]  wr_be;
  logic [DW-1:0]   rd_data;
  logic            unused_tie;

  assign adr_ext      = {1'b0, ADR_I};
  assign offset       = adr_ext - LO_ADDR;
  assign out_of_range = (adr_ext < LO_ADDR) || (adr_ext >= HI_ADDR);
  assign idx_d        = IW'(offset >> OB);
  assign bad_d        = misalign | out_of_range;

  if (OB > 0) begin : g_align_chk
    assign misalign = |ADR_I[OB-1:0];
  end else begin : g_align_none
    assign misalign = 1'b0;
  end

  // Memory commits on the edge that leaves TERM, and only if the cycle survived.
  assign wr_be = (state_q == TERM && CYC_I && we_q && !bad_q) ? sel_q : '0;

  wb_ram_bytewr #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk_i   (CLK_I),
    .be_i    (wr_be),
    .addr_i  (idx_q),
    .wdata_i (wdat_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      errt_q  <= 1'b0;
      rdat_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      wdat_q  <= '0;
      sel_q   <= '0;
    end else begin
      ack_q  <= 1'b0;
      errt_q <= 1'b0;
      rdat_q <= '0;
      case (state_q)
        IDLE: begin
          if (CYC_I && STB_I) begin
            idx_q   <= idx_d;
            we_q    <= WE_I;
            bad_q   <= bad_d;
            wdat_q  <= DAT_I;
            sel_q   <= SEL_I;
            cnt_q   <= '0;
            state_q <= (WAIT_STATES == 0) ? TERM : WAIT;
          end
        end
        WAIT: begin
          if (!CYC_I) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q + 1'b1 == WS_CNT) state_q <= TERM;
          end
        end
        TERM: begin
          state_q <= IDLE;
          if (CYC_I) begin
            ack_q  <= !bad_q;
            errt_q <= bad_q;
            if (!bad_q && !we_q) rdat_q <= rd_data;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DAT_O = rdat_q;
  assign ACK_O = ack_q;
  assign ERR_O = errt_q;
  assign RTY_O = 1'b0;
  assign TGD_O = 1'b0;

  assign unused_tie = ^{LOCK_I, TGA_I, TGC_I, TGD_I};

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mem.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_wb_slave_mem : scoreboard bench over three instances (WAIT_STATES 1, 3, 0)
// Rev 1.0
//------------------------------------------------------------------------------
module tb_wb_slave_mem;

  localparam int NI    = 3;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  typedef struct {
    int          inst;
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc [NI];
  logic        stb [NI];
  logic        we  [NI];
  logic [31:0] adr [NI];
  logic [31:0] dati[NI];
  logic [31:0] dato[NI];
  logic [3:0]  sel [NI];
  logic        ack [NI];
  logic        err [NI];
  logic        rty [NI];
  logic        tgdo[NI];
  logic        lock_i = 1'b0, tga_i = 1'b0, tgc_i = 1'b0, tgd_i = 1'b0;

  logic [31:0] mdl [NI][DEPTH];
  exp_t        sb[$];
  exp_t        mon_e;
  int          vec = 0, miss = 0, cyc_n = 0;
  int          ack_cnt[NI] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_slave_mem #(
      .DW(DW), .AW(AW), .DEPTH(DEPTH), .BASE_ADDR(0), .WAIT_STATES(ws_of(g))
    ) u_dut (
      .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[g]), .STB_I(stb[g]), .WE_I(we[g]),
      .ADR_I(adr[g]), .DAT_I(dati[g]), .SEL_I(sel[g]), .LOCK_I(lock_i),
      .TGA_I(tga_i), .TGC_I(tgc_i), .TGD_I(tgd_i), .DAT_O(dato[g]),
      .ACK_O(ack[g]), .ERR_O(err[g]), .RTY_O(rty[g]), .TGD_O(tgdo[g])
    );
  end

  // Reference rules: byte address must be word aligned and below DEPTH words.
  function automatic bit decode_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vec++;
    if (act !== expv) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // Called at the negedge that drives the request; acceptance is the next edge.
  task automatic expect_xfer(input int k, input bit w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    exp_t        e;
    logic [7:0]  wi;
    bit          bad;
    bad      = decode_err(a);
    wi       = a[9:2];
    e.inst   = k;
    e.is_err = bad;
    e.cyc    = cyc_n + 1 + ws_of(k) + 1;
    e.data   = (bad || w) ? 32'h0 : mdl[k][wi];
    if (!bad && w)
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[k][wi][8*b +: 8] = d[8*b +: 8];
    sb.push_back(e);
  endtask

  task automatic xfer(input int k, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    expect_xfer(k, w, a, d, s);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dati[k] = d; sel[k] = s;
    @(negedge clk);
    stb[k] = 1'b0; we[k] = 1'($urandom); adr[k] = $urandom;
    dati[k] = $urandom; sel[k] = 4'($urandom);
    n = 0;
    while (!(ack[k] || err[k]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vec++; miss++;
      $display("FAIL timeout inst=%0d adr=%h: no termination within 40 cycles", k, a);
    end
    cyc[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        if (ack[k] || err[k]) begin
          if (ack[k]) ack_cnt[k]++;
          vec++;
          if (sb.size() == 0 || sb[0].inst != k) begin
            miss++;
            $display("FAIL stray_strobe inst=%0d cycle=%0d: got ack=%b err=%b, want no strobe",
                     k, cyc_n, ack[k], err[k]);
          end else begin
            mon_e = sb.pop_front();
            if (ack[k] !== !mon_e.is_err || err[k] !== mon_e.is_err ||
                dato[k] !== mon_e.data || cyc_n != mon_e.cyc) begin
              miss++;
              $display("FAIL term inst=%0d: got ack=%b err=%b dat=%h cycle=%0d, want ack=%b err=%b dat=%h cycle=%0d",
                       k, ack[k], err[k], dato[k], cyc_n,
                       !mon_e.is_err, mon_e.is_err, mon_e.data, mon_e.cyc);
            end
          end
        end else if (dato[k] !== 32'h0) begin
          vec++; miss++;
          $display("FAIL dat_idle inst=%0d cycle=%0d: got %h want 0", k, cyc_n, dato[k]);
        end
      end
    end
  end

  initial begin
    int          acks0;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < NI; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = '0; dati[i] = '0; sel[i] = '0;
    end

    #12;
    for (int i = 0; i < NI; i++) begin
      chk("reset_ack", 32'(ack[i]), 32'h0);
      chk("reset_err", 32'(err[i]), 32'h0);
      chk("reset_dat", dato[i], 32'h0);
      chk("rty_tie",   32'(rty[i]), 32'h0);
      chk("tgd_tie",   32'(tgdo[i]), 32'h0);
    end
    #11 rst = 1'b0;

    // Seed the words the bench touches so every read has a known value.
    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < 16; w++) xfer(i, 1'b1, 32'(w * 4), $urandom, 4'hF);
      xfer(i, 1'b1, 32'h3FC, $urandom, 4'hF);
    end

    // WAIT_STATES=1: full write/read, byte enables, SEL=0, errors, boundary.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    xfer(0, 1'b1, 32'h10, 32'h11223344, 4'h5);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);
    xfer(0, 1'b0, 32'h400, 32'h0, 4'hF);
    xfer(0, 1'b1, 32'h13, 32'hCAFEF00D, 4'hF);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);
    xfer(0, 1'b1, 32'h0, 32'h55AA55AA, 4'h0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF);
    xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h3);
    xfer(0, 1'b1, 32'h400, 32'h12345678, 4'hF);

    // WAIT_STATES=3: abort a write to 0x20 in its second wait cycle.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h20; dati[1] = 32'hA5A55A5A; sel[1] = 4'hF;
    @(negedge clk);
    stb[1] = 1'b0;
    @(negedge clk);
    cyc[1] = 1'b0;
    repeat (8) @(negedge clk);
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF);

    // Asynchronous reset during WAIT discards a pending write to 0x30.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h30; dati[1] = 32'h0BADC0DE; sel[1] = 4'hF;
    @(negedge clk);
    stb[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ack", 32'(ack[1]), 32'h0);
    chk("rst_mid_err", 32'(err[1]), 32'h0);
    chk("rst_mid_dat", dato[1], 32'h0);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    cyc[1] = 1'b0;
    xfer(1, 1'b0, 32'h30, 32'h0, 4'hF);

    // Asynchronous reset while a read ACK is on the bus clears it at once.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10; sel[0] = 4'hF;
    @(negedge clk);
    stb[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_ack", 32'(ack[0]), 32'h1);
    chk("pre_rst_dat", dato[0], mdl[0][4]);
    rst = 1'b1;
    #1;
    chk("rst_ack_clr", 32'(ack[0]), 32'h0);
    chk("rst_dat_clr", dato[0], 32'h0);
    #1 rst = 1'b0;
    cyc[0] = 1'b0;

    // WAIT_STATES=0: four reads with CYC&STB held, one ACK every second cycle.
    acks0 = ack_cnt[2];
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      a = 32'($urandom_range(0, 15) * 4);
      expect_xfer(2, 1'b0, a, 32'h0, 4'hF);
      adr[2] = a;
      @(negedge clk);
      if (i == 3) stb[2] = 1'b0;
      @(negedge clk);
    end
    cyc[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_ack_count", 32'(ack_cnt[2] - acks0), 32'd4);

    // Randomized traffic across all three instances.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, NI - 1);
      case ($urandom_range(0, 9))
        0:       a = 32'h3FC;
        1:       a = 32'h400 + 32'($urandom_range(0, 63) * 4);
        2:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        3:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      xfer(k, 1'($urandom), a, $urandom, 4'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
